sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_if.sv | 39 +++
 rtl/sram_arbiter.sv | 98 +++++++++
 tb/tb_sram_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if
//   Bus bundle between the SRAM arbiter, its four read clients, the write
//   client and the shared single-port SRAM.
//   slave  : arbiter side (takes requests and SRAM read data, drives grants and the SRAM port)
//   master : environment side (clients + SRAM)
//   Read side : i_rd_req[3:0], i_rd_addr[4*AW-1:0] -> o_rd_grant, o_rd_valid, o_rd_tag, o_rd_data
//   Write side: i_wr_req, i_wr_addr, i_wr_data     -> o_wr_ack
//   SRAM port : o_mem_addr, o_mem_write, o_mem_data, i_mem_data (registered read, 1-cycle latency)
interface sram_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic [3:0]              i_rd_req;
  logic [4*ADDR_WIDTH-1:0] i_rd_addr;
  logic [3:0]              o_rd_grant;
  logic                    o_rd_valid;
  logic [1:0]              o_rd_tag;
  logic [DATA_WIDTH-1:0]   o_rd_data;
  logic                    i_wr_req;
  logic [ADDR_WIDTH-1:0]   i_wr_addr;
  logic [DATA_WIDTH-1:0]   i_wr_data;
  logic                    o_wr_ack;
  logic [ADDR_WIDTH-1:0]   o_mem_addr;
  logic                    o_mem_write;
  logic [DATA_WIDTH-1:0]   o_mem_data;
  logic [DATA_WIDTH-1:0]   i_mem_data;

  modport slave (
    input  i_rd_req, i_rd_addr, i_wr_req, i_wr_addr, i_wr_data, i_mem_data,
    output o_rd_grant, o_rd_valid, o_rd_tag, o_rd_data, o_wr_ack,
           o_mem_addr, o_mem_write, o_mem_data
  );

  modport master (
    output i_rd_req, i_rd_addr, i_wr_req, i_wr_addr, i_wr_data, i_mem_data,
    input  o_rd_grant, o_rd_valid, o_rd_tag, o_rd_data, o_wr_ack,
           o_mem_addr, o_mem_write, o_mem_data
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one single-port SRAM between four round-robin read clients and one
//   write client. At most one access (read, write or nothing) per cycle.
//   Reads: combinational one-hot grant in the issue cycle; data returns one
//   cycle later with o_rd_valid and the granted client index on o_rd_tag.
//   Writes: taken when no read is requested, or forced through once the write
//   client has been denied STARVE_LIMIT consecutive cycles.
//   Ports: clk, rst_n (async, active low), bus (sram_arbiter_if.slave).
//   Build option: define SRAM_ARB_WRITE_EN to enable the write client; without
//   it the write inputs are ignored and o_wr_ack/o_mem_write stay 0.
module sram_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  sram_arbiter_if.slave bus
);
  localparam int NUM_CLIENTS = 4;

  logic [1:0]            r_rr_ptr;
  logic                  r_rd_valid;
  logic [1:0]            r_rd_tag;
  logic                  w_rd_any;
  logic                  w_rd_issue;
  logic                  w_wr_issue;
  logic [1:0]            w_rd_idx;
  logic [ADDR_WIDTH-1:0] w_rd_addr;

  // Scan from the farthest offset back to rr_ptr so the nearest requester wins.
  always_comb begin
    w_rd_any = |bus.i_rd_req;
    w_rd_idx = r_rr_ptr;
    for (int j = NUM_CLIENTS-1; j >= 0; j--) begin
      if (bus.i_rd_req[r_rr_ptr + 2'(j)]) w_rd_idx = r_rr_ptr + 2'(j);
    end
  end

  assign w_rd_addr = bus.i_rd_addr[w_rd_idx*ADDR_WIDTH +: ADDR_WIDTH];

`ifdef SRAM_ARB_WRITE_EN
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] r_starve_cnt;

  // Starve count at the limit is the forced-write state: the write pre-empts reads.
  assign w_wr_issue = rst_n & bus.i_wr_req &
                      (~w_rd_any | (r_starve_cnt == SW'(STARVE_LIMIT)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             r_starve_cnt <= '0;
    else if (!bus.i_wr_req || w_wr_issue)   r_starve_cnt <= '0;
    else if (r_starve_cnt != SW'(STARVE_LIMIT)) r_starve_cnt <= r_starve_cnt + 1'b1;
  end
`else
  logic w_unused_wr;
  assign w_unused_wr = bus.i_wr_req;
  assign w_wr_issue  = 1'b0;
`endif

  // Reset gates every combinational output, not just the registers.
  assign w_rd_issue     = rst_n & w_rd_any & ~w_wr_issue;
  assign bus.o_rd_grant = w_rd_issue ? (4'd1 << w_rd_idx) : 4'd0;

  always_comb begin
    bus.o_mem_addr  = '0;
    bus.o_mem_write = 1'b0;
    bus.o_mem_data  = '0;
    bus.o_wr_ack    = 1'b0;
    if (w_wr_issue) begin
      bus.o_mem_addr  = bus.i_wr_addr;
      bus.o_mem_data  = bus.i_wr_data;
      bus.o_mem_write = 1'b1;
      bus.o_wr_ack    = 1'b1;
    end else if (w_rd_issue) begin
      bus.o_mem_addr  = w_rd_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= 2'd0;
      r_rd_valid <= 1'b0;
      r_rd_tag   <= 2'd0;
    end else begin
      r_rd_valid <= w_rd_issue;
      if (w_rd_issue) begin
        r_rd_tag <= w_rd_idx;
        r_rr_ptr <= w_rd_idx + 2'd1;
      end
    end
  end

  // SRAM output is already registered; it lines up with r_rd_valid.
  assign bus.o_rd_valid = r_rd_valid;
  assign bus.o_rd_tag   = r_rd_tag;
  assign bus.o_rd_data  = bus.i_mem_data;
endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;
  localparam int AW = 8, DW = 8, LIM = 8;
`ifdef SRAM_ARB_WRITE_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
  sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  function automatic logic [7:0] pre(input int a);
    return (a == 8'h12) ? 8'hA5 : (8'(a) ^ 8'h5A);
  endfunction

  // Environment SRAM: registered read, write-first not needed
  logic [DW-1:0] sram [256];
  logic [DW-1:0] sram_q;
  logic          mem_init = 1'b1;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) sram[i] <= pre(i);
    end else begin
      if (bus.o_mem_write) sram[bus.o_mem_addr] <= bus.o_mem_data;
      sram_q <= sram[bus.o_mem_addr];
    end
  end
  assign bus.i_mem_data = sram_q;

  // Reference model state
  int         rr, starve, ptag;
  bit         pv;
  logic [7:0] pdata;
  logic [7:0] mm [256];
  int         checks = 0, errors = 0;

  // Sampled DUT outputs
  logic [3:0] s_grant;
  logic       s_valid, s_ack, s_mw;
  logic [1:0] s_tag;
  logic [7:0] s_data, s_maddr, s_mdata;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic sample();
    s_grant = bus.o_rd_grant; s_valid = bus.o_rd_valid; s_tag = bus.o_rd_tag;
    s_data = bus.o_rd_data; s_ack = bus.o_wr_ack; s_mw = bus.o_mem_write;
    s_maddr = bus.o_mem_addr; s_mdata = bus.o_mem_data;
  endtask

  task automatic model_reset();
    rr = 0; starve = 0; pv = 1'b0; ptag = 0; pdata = '0;
  endtask

  // One clock cycle: drive at posedge+1, compare at negedge against the model.
  task automatic step(input logic [3:0] rq, input logic [31:0] ra, input logic wq,
                      input logic [7:0] wa, input logic [7:0] wd);
    int k;
    bit ew;
    logic [3:0] eg;
    logic [7:0] ea;
    bus.i_rd_req = rq; bus.i_rd_addr = ra;
    bus.i_wr_req = wq; bus.i_wr_addr = wa; bus.i_wr_data = wd;
    @(negedge clk);
    sample();
    ew = WR_EN && wq && (rq == 4'd0 || starve == LIM);
    k = -1;
    if (!ew) for (int j = 0; j < 4; j++) if (k < 0 && rq[(rr + j) % 4]) k = (rr + j) % 4;
    eg = (k >= 0) ? 4'(1 << k) : 4'd0;
    ea = ew ? wa : ((k >= 0) ? ra[k*8 +: 8] : 8'h00);
    chk("grant", 64'(s_grant), 64'(eg));
    chk("wr_ack", 64'(s_ack), 64'(ew));
    chk("mem_write", 64'(s_mw), 64'(ew));
    chk("mem_addr", 64'(s_maddr), 64'(ea));
    if (ew) chk("mem_data", 64'(s_mdata), 64'(wd));
    chk("rd_valid", 64'(s_valid), 64'(pv));
    if (pv) begin
      chk("rd_tag", 64'(s_tag), 64'(ptag));
      chk("rd_data", 64'(s_data), 64'(pdata));
    end
    pv = (k >= 0);
    if (k >= 0) begin ptag = k; pdata = mm[ea]; rr = (k + 1) % 4; end
    if (ew) mm[wa] = wd;
    if (!wq || ew) starve = 0; else if (starve < LIM) starve++;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [3:0]  rq;
    logic [31:0] ra;
    logic [3:0]  eg;
    logic        ev;
    logic [1:0]  et;
    logic        cd;
    logic [7:0]  ed;
  } vec_t;
  vec_t tbl [12];

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic       wq;
    // Round-robin sweep, then a directed read of the preloaded 0x12 by client 2.
    for (int i = 0; i < 8; i++)
      tbl[i] = '{4'b1111, 32'h03020100, 4'(1 << (i % 4)), (i != 0), 2'((i + 3) % 4), 1'b0, 8'h00};
    tbl[8]  = '{4'b0000, 32'h0, 4'b0000, 1'b1, 2'd3, 1'b1, 8'h59};
    tbl[9]  = '{4'b0000, 32'h0, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00};
    tbl[10] = '{4'b0100, 32'h00120000, 4'b0100, 1'b0, 2'd0, 1'b0, 8'h00};
    tbl[11] = '{4'b0000, 32'h0, 4'b0000, 1'b1, 2'd2, 1'b1, 8'hA5};

    for (int i = 0; i < 256; i++) mm[i] = pre(i);
    bus.i_rd_req = 4'b1111; bus.i_rd_addr = 32'h04030201;
    bus.i_wr_req = 1'b1; bus.i_wr_addr = 8'h33; bus.i_wr_data = 8'h77;
    repeat (3) @(posedge clk);
    @(negedge clk);
    sample();
    chk("rst_grant", 64'(s_grant), 64'd0);
    chk("rst_valid", 64'(s_valid), 64'd0);
    chk("rst_tag", 64'(s_tag), 64'd0);
    chk("rst_ack", 64'(s_ack), 64'd0);
    chk("rst_mem_write", 64'(s_mw), 64'd0);
    chk("rst_mem_addr", 64'(s_maddr), 64'd0);
    chk("rst_mem_data", 64'(s_mdata), 64'd0);
    mem_init = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rq, tbl[i].ra, 1'b0, 8'h0, 8'h0);
      chk("tbl_grant", 64'(s_grant), 64'(tbl[i].eg));
      chk("tbl_valid", 64'(s_valid), 64'(tbl[i].ev));
      if (tbl[i].ev) chk("tbl_tag", 64'(s_tag), 64'(tbl[i].et));
      if (tbl[i].cd) chk("tbl_data", 64'(s_data), 64'(tbl[i].ed));
    end

`ifdef SRAM_ARB_WRITE_EN
    // Idle-bus write, then read it back
    step(4'b0000, 32'h0, 1'b1, 8'h20, 8'h3C);
    chk("wr_ack_idle", 64'(s_ack), 64'd1);
    chk("wr_mw_idle", 64'(s_mw), 64'd1);
    step(4'b0001, 32'h00000020, 1'b0, 8'h0, 8'h0);
    chk("rb_grant", 64'(s_grant), 64'd1);
    step(4'b0000, 32'h0, 1'b0, 8'h0, 8'h0);
    chk("rb_valid", 64'(s_valid), 64'd1);
    chk("rb_data", 64'(s_data), 64'h3C);
    // Starvation: 8 reads, forced write on the 9th, then reads resume
    for (int i = 0; i < 10; i++) begin
      step(4'b0001, 32'h00000005, 1'b1, 8'h40, 8'(i));
      if (i < 8) begin
        chk("starve_rd_grant", 64'(s_grant), 64'd1);
        chk("starve_rd_ack", 64'(s_ack), 64'd0);
      end else if (i == 8) begin
        chk("force_grant", 64'(s_grant), 64'd0);
        chk("force_ack", 64'(s_ack), 64'd1);
      end else begin
        chk("resume_grant", 64'(s_grant), 64'd1);
      end
    end
    step(4'b0000, 32'h0, 1'b0, 8'h0, 8'h0);
`else
    for (int i = 0; i < 20; i++) begin
      step(4'(i), $urandom, 1'b1, 8'($urandom), 8'($urandom));
      chk("nowr_ack", 64'(s_ack), 64'd0);
      chk("nowr_mw", 64'(s_mw), 64'd0);
    end
    step(4'b0000, 32'h0, 1'b0, 8'h0, 8'h0);
`endif

    // Reset right after a grant: in-flight read discarded, pointer back to 0
    step(4'b1111, 32'h03020100, 1'b0, 8'h0, 8'h0);
    rst_n = 1'b0;
    @(negedge clk);
    sample();
    chk("rst_mid_valid", 64'(s_valid), 64'd0);
    chk("rst_mid_grant", 64'(s_grant), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    step(4'b1111, 32'h03020100, 1'b0, 8'h0, 8'h0);
    chk("rel_first_grant", 64'(s_grant), 64'd1);
    chk("rel_valid", 64'(s_valid), 64'd0);

    // Random traffic against the model; sticky write request to reach starvation
    wq = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 7) == 0) wq = ~wq;
      step(4'($urandom_range(0, 15)), $urandom & 32'h0F0F0F0F, wq,
           8'($urandom_range(0, 15)), 8'($urandom));
    end
    step(4'b0000, 32'h0, 1'b0, 8'h0, 8'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
